// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- definitions shared by the two-port memory arbiter.
//   state_t : FSM state encoding (IDLE / ACCESS / RESP)
//   PORT_I  : id of port 0 (instruction fetch)
//   PORT_D  : id of port 1 (data access)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2 -- combinational 2-input round-robin grant.
//   i_req   [1:0] : request vector, bit N = port N
//   i_ptr         : port favoured when both request
//   o_valid       : at least one request present
//   o_grant       : id of the granted port (meaningful when o_valid)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_valid,
  output logic       o_grant
);

  always_comb begin
    o_valid = |i_req;
    o_grant = PORT_I;
    if (i_req[0] && i_req[1]) begin
      o_grant = i_ptr;
    end else if (i_req[1]) begin
      o_grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates two request ports onto one external memory.
//   Clock, ResetN                 : clock, synchronous active-low reset
//   Req/We/Addr/WData 0 and 1     : per-port request, held until its Ack
//   Ack0/Ack1, RData0/RData1      : per-port completion pulse and read data
//   MemStatus/MemAddress/MemI     : memory control (1 = write), address, wdata
//   MemQ                          : memory read data, combinational from MemAddress
//   Busy                          : high whenever the FSM is not IDLE
//   DbgState                      : current FSM state, for observation
//
// Handshake: a port raises Req with We/Addr/WData stable and keeps them
// stable until its Ack pulse. At the edge ending the Ack cycle the port
// either drops Req or keeps it high to issue the next request; IDLE samples
// whatever is present then. Each access is IDLE -> ACCESS -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WordSize  = 32,
  parameter int AddrWidth = 8
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Req0,
  input  logic                 We0,
  input  logic [AddrWidth-1:0] Addr0,
  input  logic [WordSize-1:0]  WData0,
  output logic                 Ack0,
  output logic [WordSize-1:0]  RData0,
  input  logic                 Req1,
  input  logic                 We1,
  input  logic [AddrWidth-1:0] Addr1,
  input  logic [WordSize-1:0]  WData1,
  output logic                 Ack1,
  output logic [WordSize-1:0]  RData1,
  output logic                 MemStatus,
  output logic [AddrWidth-1:0] MemAddress,
  output logic [WordSize-1:0]  MemI,
  input  logic [WordSize-1:0]  MemQ,
  output logic                 Busy,
  output logic [1:0]           DbgState
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_ptr;
  logic                 r_win;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr;
  logic [WordSize-1:0]  r_wdata;
  logic [WordSize-1:0]  r_rdata0;
  logic [WordSize-1:0]  r_rdata1;
  logic                 w_gnt_valid;
  logic                 w_gnt;

  rr_arb2 u_rr_arb2 (
    .i_req   ({Req1, Req0}),
    .i_ptr   (r_ptr),
    .o_valid (w_gnt_valid),
    .o_grant (w_gnt)
  );

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    Ack0         = 1'b0;
    Ack1         = 1'b0;
    MemStatus    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        // The only place a write strobe can appear.
        MemStatus    = r_we;
        w_next_state = RESP;
      end
      RESP: begin
        Ack0         = (r_win == PORT_I);
        Ack1         = (r_win == PORT_D);
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_ptr    <= PORT_I;
      r_win    <= PORT_I;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_win   <= w_gnt;
            r_we    <= (w_gnt == PORT_D) ? We1    : We0;
            r_addr  <= (w_gnt == PORT_D) ? Addr1  : Addr0;
            r_wdata <= (w_gnt == PORT_D) ? WData1 : WData0;
          end
        end
        ACCESS: begin
          if (!r_we) begin
            if (r_win == PORT_D) begin
              r_rdata1 <= MemQ;
            end else begin
              r_rdata0 <= MemQ;
            end
          end
        end
        RESP: begin
          // Favour the port that was not just served.
          r_ptr <= ~r_win;
        end
        default: begin
        end
      endcase
    end
  end

  // Address and write data come straight from the latch so they hold
  // their values outside ACCESS.
  assign MemAddress = r_addr;
  assign MemI       = r_wdata;
  assign RData0     = r_rdata0;
  assign RData1     = r_rdata1;
  assign Busy       = (r_state != IDLE);
  assign DbgState   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter with a small external
// memory model and an ack scoreboard.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int A = 8;

  // clock / reset
  logic         Clock = 1'b0;
  logic         ResetN;
  logic         Req0, We0, Req1, We1;
  logic [A-1:0] Addr0, Addr1;
  logic [W-1:0] WData0, WData1;
  logic         Ack0, Ack1, MemStatus, Busy;
  logic [W-1:0] RData0, RData1, MemI, MemQ;
  logic [A-1:0] MemAddress;
  logic [1:0]   DbgState;

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  mem_arbiter #(.WordSize(W), .AddrWidth(A)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
    .Ack0(Ack0), .RData0(RData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
    .Ack1(Ack1), .RData1(RData1),
    .MemStatus(MemStatus), .MemAddress(MemAddress), .MemI(MemI),
    .MemQ(MemQ), .Busy(Busy), .DbgState(DbgState)
  );

  // external memory model
  logic [W-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 32'h1111_0001;
    mem[2] = 32'h2222_0002;
  end
  always @(posedge Clock) if (MemStatus) mem[MemAddress] <= MemI;
  assign MemQ = mem[MemAddress];

  // scoreboard: {port, rdata0, rdata1} and the cycle the ack must appear in
  logic [2*W:0] exp_q[$];
  int           exp_t_q[$];
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic p, input logic [W-1:0] r0, input logic [W-1:0] r1, input int t);
    exp_q.push_back({p, r0, r1});
    exp_t_q.push_back(t);
  endtask

  // monitor
  int           ms_cycles = 0;
  logic [A-1:0] ms_addr;
  logic [W-1:0] ms_data;

  always @(negedge Clock) begin
    logic [2*W:0] e;
    int           t;
    if (MemStatus) begin
      ms_cycles++;
      ms_addr = MemAddress;
      ms_data = MemI;
    end
    if (Ack0 || Ack1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=ack0:%0b,ack1:%0b cyc=%0d required=no ack", Ack0, Ack1, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("ack_onehot", 64'(Ack0 & Ack1), 64'd0);
        check("ack_port", 64'(Ack1), 64'(e[2*W]));
        check("ack_cycle", 64'(cyc), 64'(t));
        check("rdata0", 64'(RData0), 64'(e[2*W-1:W]));
        check("rdata1", 64'(RData1), 64'(e[W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic req_port(input logic p, input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
    if (p) begin
      Req1 = 1'b1; We1 = we; Addr1 = a; WData1 = d;
    end else begin
      Req0 = 1'b1; We0 = we; Addr0 = a; WData0 = d;
    end
  endtask

  task automatic drop_port(input logic p);
    if (p) Req1 = 1'b0;
    else   Req0 = 1'b0;
  endtask

  // Waits for the port's ack, then returns just after the edge ending it.
  task automatic wait_ack(input logic p, input int budget);
    int n = 0;
    @(negedge Clock);
    while (!(p ? Ack1 : Ack0) && n < budget) begin
      n++;
      @(negedge Clock);
    end
    if (n >= budget) check("ack_timeout", 64'(n), 64'(budget - 1));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    ResetN = 1'b1;
  endtask

  initial begin
    int c;
    int ms0;
    int n;
    ResetN = 1'b0;
    Req0 = 0; We0 = 0; Addr0 = '0; WData0 = '0;
    Req1 = 0; We1 = 0; Addr1 = '0; WData1 = '0;

    // reset values
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_state", 64'(DbgState), 64'd0);
    check("rst_ack0", 64'(Ack0), 64'd0);
    check("rst_ack1", 64'(Ack1), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_memstatus", 64'(MemStatus), 64'd0);
    check("rst_memaddr", 64'(MemAddress), 64'd0);
    check("rst_memi", 64'(MemI), 64'd0);
    check("rst_rdata0", 64'(RData0), 64'd0);
    check("rst_rdata1", 64'(RData1), 64'd0);
    @(posedge Clock);
    #1;
    ResetN = 1'b1;

    // port 1 write DEADBEEF to 0x05
    ms0 = ms_cycles;
    c = cyc;
    push_exp(1'b1, 32'h0, 32'h0, c + 2);
    req_port(1'b1, 1'b1, 8'h05, 32'hDEADBEEF);
    wait_ack(1'b1, 10);
    drop_port(1'b1);
    check("wr_strobe_cycles", 64'(ms_cycles - ms0), 64'd1);
    check("wr_strobe_addr", 64'(ms_addr), 64'h05);
    check("wr_strobe_data", 64'(ms_data), 64'hDEADBEEF);
    check("hold_memaddr", 64'(MemAddress), 64'h05);

    // port 0 reads it back
    ms0 = ms_cycles;
    c = cyc;
    push_exp(1'b0, 32'hDEADBEEF, 32'h0, c + 2);
    req_port(1'b0, 1'b0, 8'h05, 32'h0);
    wait_ack(1'b0, 10);
    drop_port(1'b0);
    check("rd_no_strobe", 64'(ms_cycles - ms0), 64'd0);

    // reset during ACCESS of a write: no ack, idle the next cycle
    req_port(1'b0, 1'b1, 8'h07, 32'h1234_5678);
    @(posedge Clock);
    @(negedge Clock);
    check("mid_state_access", 64'(DbgState), 64'd1);
    check("mid_memstatus_wr", 64'(MemStatus), 64'd1);
    ResetN = 1'b0;
    drop_port(1'b0);
    @(posedge Clock);
    @(negedge Clock);
    check("abort_memstatus", 64'(MemStatus), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_state", 64'(DbgState), 64'd0);
    check("abort_ack0", 64'(Ack0), 64'd0);
    @(posedge Clock);
    #1;
    ResetN = 1'b1;

    // both ports held, reads of 0x01 / 0x02: port 0 first, then alternate
    ms0 = ms_cycles;
    c = cyc;
    push_exp(1'b0, 32'h1111_0001, 32'h0,         c + 2);
    push_exp(1'b1, 32'h1111_0001, 32'h2222_0002, c + 5);
    push_exp(1'b0, 32'h1111_0001, 32'h2222_0002, c + 8);
    push_exp(1'b1, 32'h1111_0001, 32'h2222_0002, c + 11);
    req_port(1'b0, 1'b0, 8'h01, 32'h0);
    req_port(1'b1, 1'b0, 8'h02, 32'h0);
    repeat (11) @(posedge Clock);
    @(posedge Clock);
    #1;
    drop_port(1'b0);
    drop_port(1'b1);
    check("both_no_strobe", 64'(ms_cycles - ms0), 64'd0);

    // port 0 alone, 4 back-to-back reads of 0x05
    ms0 = ms_cycles;
    c = cyc;
    for (int k = 0; k < 4; k++)
      push_exp(1'b0, 32'hDEADBEEF, 32'h2222_0002, c + 2 + 3 * k);
    req_port(1'b0, 1'b0, 8'h05, 32'h0);
    repeat (11) @(posedge Clock);
    @(posedge Clock);
    #1;
    drop_port(1'b0);
    check("stream_no_strobe", 64'(ms_cycles - ms0), 64'd0);

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(posedge Clock);
    end
    repeat (4) @(posedge Clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
